// File: rtl/reg_bank.sv
// -----------------------------------------------------------------------------
// reg_bank
// A small bank of DEPTH registers, each WIDTH bits wide, with a single-cycle
// operation unit (load, increment, decrement, shifts, rotates through carry,
// clear) and a shared {N,Z,C} status register.
//
// Parameters
//   WIDTH  register and bus width in bits (2..32)
//   DEPTH  number of registers (2..16)
//
// Ports
//   clk     rising-edge clock for all state
//   clr     asynchronous active-high reset: registers -> 0, flags -> 3'b010
//   bus     write data for LOAD
//   sel     register index used for both the operation and the read port
//   wa      operation enable; op is only honoured while wa=1
//   op      operation code
//   oa      read enable; busout is all zeros when oa=0 or sel is out of range
//   busout  combinational view of register[sel] (never tri-stated)
//   flags   {N,Z,C} status register
// -----------------------------------------------------------------------------
module reg_bank #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int SELW  = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] bus,
    input  logic [SELW-1:0]  sel,
    input  logic             wa,
    input  logic [2:0]       op,
    input  logic             oa,
    output logic [WIDTH-1:0] busout,
    output logic [2:0]       flags
);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_DEC  = 3'b010;
    localparam logic [2:0] OP_ASL  = 3'b011;
    localparam logic [2:0] OP_LSR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SELW:0]    DEPTH_L = (SELW+1)'(DEPTH);
    localparam logic [2:0]       FLAGS_RESET = 3'b010;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [2:0]       r_flags;

    logic             w_sel_valid;
    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_res;
    logic             w_c;

    // Index range check; only matters when DEPTH is not a power of two.
    assign w_sel_valid = ({1'b0, sel} < DEPTH_L);

    // Select the addressed register; out-of-range indices read as zero.
    always_comb begin
        if (w_sel_valid) begin
            w_cur = r_regs[sel];
        end else begin
            w_cur = '0;
        end
    end

    // Operation unit: next value and next carry for the addressed register.
    // Rotates use the carry held before the edge; LOAD/CLR keep the carry.
    always_comb begin
        w_res = '0;
        w_c   = r_flags[0];
        case (op)
            OP_LOAD: begin
                w_res = bus;
                w_c   = r_flags[0];
            end
            OP_INC: begin
                w_res = w_cur + ONE;
                w_c   = &w_cur;
            end
            OP_DEC: begin
                w_res = w_cur - ONE;
                w_c   = (w_cur == '0);
            end
            OP_ASL: begin
                w_res = {w_cur[WIDTH-2:0], 1'b0};
                w_c   = w_cur[WIDTH-1];
            end
            OP_LSR: begin
                w_res = {1'b0, w_cur[WIDTH-1:1]};
                w_c   = w_cur[0];
            end
            OP_ROL: begin
                w_res = {w_cur[WIDTH-2:0], r_flags[0]};
                w_c   = w_cur[WIDTH-1];
            end
            OP_ROR: begin
                w_res = {r_flags[0], w_cur[WIDTH-1:1]};
                w_c   = w_cur[0];
            end
            OP_CLR: begin
                w_res = '0;
                w_c   = r_flags[0];
            end
            default: begin
                w_res = '0;
                w_c   = r_flags[0];
            end
        endcase
    end

    // Register and flag update; only the addressed register changes.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_flags <= FLAGS_RESET;
        end else if (wa && w_sel_valid) begin
            r_regs[sel] <= w_res;
            r_flags     <= {w_res[WIDTH-1], (w_res == '0), w_c};
        end
    end

    // Read port is combinational: no bypass of a write in progress.
    always_comb begin
        if (oa) begin
            busout = w_cur;
        end else begin
            busout = '0;
        end
    end

    assign flags = r_flags;

endmodule

// File: tb/tb_reg_bank.sv
module tb_reg_bank;

    // Default instance: WIDTH=8, DEPTH=4
    logic       clk;
    logic       clr;
    logic [7:0] bus;
    logic [1:0] sel;
    logic       wa;
    logic [2:0] op;
    logic       oa;
    logic [7:0] busout;
    logic [2:0] flags;

    // Small instance: WIDTH=4, DEPTH=3
    logic       clr_s;
    logic [3:0] bus_s;
    logic [1:0] sel_s;
    logic       wa_s;
    logic [2:0] op_s;
    logic       oa_s;
    logic [3:0] busout_s;
    logic [2:0] flags_s;

    int errors;
    int checks;

    reg_bank #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .clr(clr), .bus(bus), .sel(sel), .wa(wa), .op(op),
        .oa(oa), .busout(busout), .flags(flags)
    );

    reg_bank #(.WIDTH(4), .DEPTH(3)) dut_s (
        .clk(clk), .clr(clr_s), .bus(bus_s), .sel(sel_s), .wa(wa_s), .op(op_s),
        .oa(oa_s), .busout(busout_s), .flags(flags_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One accepted operation on the 8-bit bank; returns at posedge+1.
    task automatic do_op(input logic [1:0] s, input logic [2:0] o, input logic [7:0] d);
        @(negedge clk);
        sel = s; op = o; bus = d; wa = 1'b1;
        @(posedge clk);
        #1;
        wa = 1'b0;
    endtask

    // One operation on the 4-bit bank; returns at posedge+1.
    task automatic do_op_s(input logic [1:0] s, input logic [2:0] o, input logic [3:0] d);
        @(negedge clk);
        sel_s = s; op_s = o; bus_s = d; wa_s = 1'b1;
        @(posedge clk);
        #1;
        wa_s = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] exp_v;
        for (int i = 0; i < 4; i++) begin
            do_op(i[1:0], 3'b000, 8'hFF);
        end
        @(negedge clk);
        oa = 1'b1; sel = 2'd3;
        #1;
        exp_v = 8'hFF;
        checks++;
        if (busout !== exp_v) begin
            errors++;
            $display("FAIL preload_ff: busout=%h expected %h", busout, exp_v);
        end
        clr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = i[1:0];
            #1;
            checks++;
            if (busout !== 8'h00) begin
                errors++;
                $display("FAIL reset_read sel=%0d: busout=%h expected 00", i, busout);
            end
        end
        checks++;
        if (flags !== 3'b010) begin
            errors++;
            $display("FAIL reset_flags: flags=%b expected 010", flags);
        end
        // Operation requested while clr is held must be discarded.
        sel = 2'd0; op = 3'b000; bus = 8'h55; wa = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busout !== 8'h00 || flags !== 3'b010) begin
            errors++;
            $display("FAIL op_during_reset: busout=%h flags=%b expected 00 010", busout, flags);
        end
        @(negedge clk);
        wa = 1'b0; clr = 1'b0;
        #1;
        checks++;
        if (busout !== 8'h00) begin
            errors++;
            $display("FAIL after_reset_release: busout=%h expected 00", busout);
        end
    endtask

    task automatic test_load_read;
        do_op(2'd1, 3'b000, 8'h29);
        oa = 1'b1; sel = 2'd1;
        #1;
        checks++;
        if (busout !== 8'h29 || flags !== 3'b000) begin
            errors++;
            $display("FAIL load_read: busout=%h flags=%b expected 29 000", busout, flags);
        end
        for (int i = 0; i < 4; i++) begin
            if (i != 1) begin
                sel = i[1:0];
                #1;
                checks++;
                if (busout !== 8'h00) begin
                    errors++;
                    $display("FAIL load_others sel=%0d: busout=%h expected 00", i, busout);
                end
            end
        end
    endtask

    task automatic test_wrap;
        do_op(2'd2, 3'b000, 8'hFF);
        do_op(2'd2, 3'b001, 8'h00);
        sel = 2'd2; oa = 1'b1;
        #1;
        checks++;
        if (busout !== 8'h00 || flags !== 3'b011) begin
            errors++;
            $display("FAIL inc_wrap: busout=%h flags=%b expected 00 011", busout, flags);
        end
        do_op(2'd2, 3'b010, 8'h00);
        sel = 2'd2;
        #1;
        checks++;
        if (busout !== 8'hFF || flags !== 3'b101) begin
            errors++;
            $display("FAIL dec_wrap: busout=%h flags=%b expected ff 101", busout, flags);
        end
    endtask

    task automatic test_shift_rotate;
        logic [2:0]  ops [5];
        logic [7:0]  exp_v [5];
        logic [2:0]  exp_f [5];
        ops[0] = 3'b000; exp_v[0] = 8'h81; exp_f[0] = 3'b101;
        ops[1] = 3'b011; exp_v[1] = 8'h02; exp_f[1] = 3'b001;
        ops[2] = 3'b101; exp_v[2] = 8'h05; exp_f[2] = 3'b000;
        ops[3] = 3'b110; exp_v[3] = 8'h02; exp_f[3] = 3'b001;
        ops[4] = 3'b100; exp_v[4] = 8'h01; exp_f[4] = 3'b000;
        for (int i = 0; i < 5; i++) begin
            do_op(2'd3, ops[i], 8'h81);
            sel = 2'd3; oa = 1'b1;
            #1;
            checks++;
            if (busout !== exp_v[i] || flags !== exp_f[i]) begin
                errors++;
                $display("FAIL shift_step%0d: busout=%h flags=%b expected %h %b",
                         i, busout, flags, exp_v[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_hold_and_clr_op;
        // wa=0 must leave state alone even with an active op.
        @(negedge clk);
        sel = 2'd3; op = 3'b111; wa = 1'b0; oa = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busout !== 8'h01 || flags !== 3'b000) begin
            errors++;
            $display("FAIL wa0_hold: busout=%h flags=%b expected 01 000", busout, flags);
        end
        // Decrement of zero sets carry; register 0 untouched so far.
        do_op(2'd0, 3'b010, 8'h00);
        sel = 2'd0;
        #1;
        checks++;
        if (busout !== 8'hFF || flags !== 3'b101) begin
            errors++;
            $display("FAIL dec_zero: busout=%h flags=%b expected ff 101", busout, flags);
        end
        do_op(2'd0, 3'b111, 8'hAA);
        sel = 2'd0;
        #1;
        checks++;
        if (busout !== 8'h00 || flags !== 3'b011) begin
            errors++;
            $display("FAIL clr_op: busout=%h flags=%b expected 00 011", busout, flags);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        oa = 1'b0; sel = 2'd1;
        #1;
        checks++;
        if (busout !== 8'h00) begin
            errors++;
            $display("FAIL oa_gate: busout=%h expected 00", busout);
        end
        oa = 1'b1; wa = 1'b1; op = 3'b000; bus = 8'h10;
        #1;
        checks++;
        if (busout !== 8'h29) begin
            errors++;
            $display("FAIL pre_edge_read: busout=%h expected 29", busout);
        end
        @(posedge clk);
        #1;
        wa = 1'b0;
        checks++;
        if (busout !== 8'h10) begin
            errors++;
            $display("FAIL post_edge_read: busout=%h expected 10", busout);
        end
    endtask

    task automatic test_param_sweep;
        @(negedge clk);
        clr_s = 1'b1;
        #1;
        clr_s = 1'b0;
        do_op_s(2'd0, 3'b000, 4'hF);
        checks++;
        if (flags_s !== 3'b100) begin
            errors++;
            $display("FAIL small_load_flags: flags=%b expected 100", flags_s);
        end
        do_op_s(2'd3, 3'b000, 4'h5);
        oa_s = 1'b1; sel_s = 2'd3;
        #1;
        checks++;
        if (busout_s !== 4'h0 || flags_s !== 3'b100) begin
            errors++;
            $display("FAIL small_oob_write: busout=%h flags=%b expected 0 100", busout_s, flags_s);
        end
        for (int i = 0; i < 3; i++) begin
            sel_s = i[1:0];
            #1;
            checks++;
            if (busout_s !== ((i == 0) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL small_regs sel=%0d: busout=%h expected %h",
                         i, busout_s, ((i == 0) ? 4'hF : 4'h0));
            end
        end
        do_op_s(2'd0, 3'b001, 4'h0);
        sel_s = 2'd0;
        #1;
        checks++;
        if (busout_s !== 4'h0 || flags_s !== 3'b011) begin
            errors++;
            $display("FAIL small_inc_wrap: busout=%h flags=%b expected 0 011", busout_s, flags_s);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clr = 1'b1; bus = 8'h00; sel = 2'd0; wa = 1'b0; op = 3'b000; oa = 1'b0;
        clr_s = 1'b1; bus_s = 4'h0; sel_s = 2'd0; wa_s = 1'b0; op_s = 3'b000; oa_s = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0; clr_s = 1'b0;
        test_reset;
        test_load_read;
        test_wrap;
        test_shift_rotate;
        test_hold_and_clr_op;
        test_back_to_back;
        test_param_sweep;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register and bus width in bits (range 2-32).
REQ-002 SHALL have parameter DEPTH, default 4, number of registers (range 2-16); SELW = max(1, ceil(log2 DEPTH)).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port bus  input  WIDTH  write data bus.
REQ-006 SHALL have port sel  input  SELW  register index for both write and read.
REQ-007 SHALL have port wa  input  1  write/operate enable.
REQ-008 SHALL have port op  input  3  operation code, sampled only when wa=1.
REQ-009 SHALL have port oa  input  1  output enable.
REQ-010 SHALL have port busout  output  WIDTH  selected register value; never tri-stated.
REQ-011 SHALL have port flags  output  3  {N,Z,C} status register.

Function
REQ-012 SHALL hold DEPTH registers of WIDTH bits plus a 3-bit flag register.
REQ-013 busout SHALL equal register[sel] combinationally when oa=1 and sel<DEPTH, else all zeros.
REQ-014 With wa=1 and sel<DEPTH, register[sel] SHALL update at the rising clk edge with result R of op:
  000 LOAD: R=bus; 001 INC: R=reg+1 mod 2^WIDTH; 010 DEC: R=reg-1 mod 2^WIDTH; 011 ASL: R={reg[WIDTH-2:0],0}; 100 LSR: R={0,reg[WIDTH-1:1]}; 101 ROL: R={reg[WIDTH-2:0],C}; 110 ROR: R={C,reg[WIDTH-1:1]}; 111 CLR: R=0.
REQ-015 ROL/ROR SHALL use the C flag value held before the edge.
REQ-016 On every accepted operation Z SHALL become (R==0) and N SHALL become R[WIDTH-1].
REQ-017 C SHALL become: ASL/ROL old reg[WIDTH-1]; LSR/ROR old reg[0]; INC 1 iff old reg all ones; DEC 1 iff old reg zero; LOAD/CLR C unchanged.
REQ-018 With wa=0 no register or flag SHALL change.
REQ-019 With wa=1 and sel>=DEPTH (non-power-of-two DEPTH) no register or flag SHALL change.
REQ-020 Simultaneous wa=1 and oa=1 on the same sel SHALL show the pre-edge value on busout until the edge, the new value after it (no bypass).
REQ-021 Write latency SHALL be one edge; read latency SHALL be zero (combinational).
REQ-022 Only register[sel] SHALL change per edge; all others hold.

Reset
REQ-023 clr=1 SHALL immediately, without a clock edge, force all registers to 0 and flags to 3'b010 (Z=1, N=0, C=0).
REQ-024 While clr=1, clock edges SHALL have no effect, including wa=1 operations.
REQ-025 An operation whose edge coincides with clr=1 SHALL be discarded; first update occurs on the first edge with clr=0.
REQ-026 busout SHALL reflect the reset (zero) value during reset when oa=1.

Verification
REQ-027 Reset then read: pulse clr mid-cycle with all registers loaded 8'hFF -> busout=8'h00 for every sel with oa=1 before the next edge, flags=3'b010.
REQ-028 Load/read: sel=1, wa=1, op=000, bus=8'h29 for one edge, then oa=1 -> busout=8'h29, flags N=0,Z=0, C unchanged; registers 0,2,3 remain 8'h00.
REQ-029 Wrap-around: load 8'hFF, INC -> 8'h00, Z=1, C=1, N=0; then DEC -> 8'hFF, N=1, Z=0, C=1.
REQ-030 Shift/rotate chain: load 8'h81, ASL -> 8'h02, C=1; ROL -> 8'h05, C=0; ROR -> 8'h02, C=1; LSR -> 8'h01, C=0.
REQ-031 Output gating and simultaneity: oa=0 -> busout=8'h00; oa=1 with wa=1 LOAD 8'h10 to register holding 8'h29 -> busout 8'h29 before edge, 8'h10 after.
REQ-032 Parameter sweep: WIDTH=4, DEPTH=3; write with sel=3 -> no state change, busout=0 for sel=3; INC of 4'hF -> 4'h0, C=1.
